// File: rtl/inst_sram_axi_bridge_if.sv
// Bus bundle between the IF1 fetch stage, the instruction SRAM-like port of
// inst_sram_axi_bridge and the AXI read channels (AR and R) it drives.
//
// Signal groups:
//   fetch side : inst_sram_req/size/addr, inst_uncache, inst_sram_cancel (to bridge)
//                inst_sram_addr_ok/data_ok/rdata/rvalid1/err       (from bridge)
//   AXI AR     : arid/araddr/arlen/arsize/arburst/arcache/arvalid (from bridge),
//                arready (to bridge)
//   AXI R      : rid/rdata/rresp/rlast/rvalid (to bridge), rready (from bridge)
//
// Modports:
//   slave  : the bridge, which responds to fetch requests
//   master : the surroundings (fetch stage plus AXI slave)
interface inst_sram_axi_bridge_if;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_uncache;
  logic        inst_sram_cancel;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [63:0] inst_sram_rdata;
  logic        inst_sram_rvalid1;
  logic        inst_sram_err;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  inst_sram_req, inst_sram_size, inst_sram_addr, inst_uncache, inst_sram_cancel,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_rvalid1,
    output inst_sram_err,
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport master (
    output inst_sram_req, inst_sram_size, inst_sram_addr, inst_uncache, inst_sram_cancel,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_rvalid1,
    input  inst_sram_err,
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch bridge: turns each accepted SRAM-like fetch request into
// one 2-beat x 32-bit AXI4 INCR read burst aligned to 8 bytes, and returns the
// 64-bit instruction pair in request order with a one-cycle data_ok pulse.
// Requests flushed by inst_sram_cancel still complete on the bus (AXI cannot
// abort a burst) but their data is dropped without a data_ok.
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : inst_sram_axi_bridge_if.slave (fetch side + AXI AR/R channels)
//
// Parameters:
//   MAX_OUT  : accepted-but-unanswered requests allowed (1..4)
//   ARID_VAL : constant ARID for every burst
module inst_sram_axi_bridge #(
  parameter int         MAX_OUT  = 2,
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input logic                   clk,
  input logic                   reset,
  inst_sram_axi_bridge_if.slave bus
);

  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUT);
  localparam logic [1:0] LAST_PTR = 2'(MAX_OUT - 1);

  // In-flight request FIFO: a2 remembers which half of the pair was asked
  // for, cxl marks an entry whose data must be discarded.
  logic        a2_q  [4];
  logic        cxl_q [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  cnt;

  // Beat assembly state for the burst currently on the R channel.
  logic        beat;
  logic [31:0] lo;
  logic        err_acc;

  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [3:0]  arcache_q;
  logic        rready_q;
  logic        data_ok_q;
  logic [63:0] rdata_q;
  logic        rvalid1_q;
  logic        err_q;

  logic        accept;
  logic        r_fire;
  logic        complete;
  logic        beat_err;
  logic        head_cxl;
  logic [31:0] lo_eff;
  logic        err_total;
  logic        unused_bits;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Only one AR may be outstanding, so a new request waits for the previous
  // address handshake; a flush cycle never accepts. A rlast with nothing in
  // flight is ignored. A rlast without a preceding beat leaves lo at zero,
  // and the completing entry counts as cancelled if the flush lands now.
  always_comb begin
    accept    = bus.inst_sram_req && !arvalid_q && (cnt < MAX_CNT) && !bus.inst_sram_cancel;
    r_fire    = bus.rvalid && rready_q;
    complete  = r_fire && bus.rlast && (cnt != 3'd0);
    beat_err  = (bus.rresp != 2'b00);
    lo_eff    = beat ? lo : 32'd0;
    err_total = (beat && err_acc) || beat_err;
    head_cxl  = cxl_q[rd_ptr] || bus.inst_sram_cancel;
  end

  // All request tracking, AR issue, beat assembly and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      cnt       <= 3'd0;
      beat      <= 1'b0;
      lo        <= 32'd0;
      err_acc   <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arcache_q <= 4'd0;
      rready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= 64'd0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a2_q[i]  <= 1'b0;
        cxl_q[i] <= 1'b0;
      end
    end else begin
      rready_q  <= 1'b1;
      data_ok_q <= 1'b0;

      // A flush condemns every live entry, including one whose AR is pending.
      if (bus.inst_sram_cancel) begin
        for (int i = 0; i < 4; i++) begin
          cxl_q[i] <= 1'b1;
        end
      end

      if (accept) begin
        arvalid_q      <= 1'b1;
        araddr_q       <= {bus.inst_sram_addr[31:3], 3'b000};
        arcache_q      <= bus.inst_uncache ? 4'b0000 : 4'b1111;
        a2_q[wr_ptr]   <= bus.inst_sram_addr[2];
        cxl_q[wr_ptr]  <= 1'b0;
        wr_ptr         <= ptr_next(wr_ptr);
      end else if (arvalid_q && bus.arready) begin
        arvalid_q <= 1'b0;
      end

      if (r_fire) begin
        if (!bus.rlast) begin
          lo      <= bus.rdata;
          err_acc <= beat_err;
          beat    <= 1'b1;
        end else begin
          lo      <= 32'd0;
          err_acc <= 1'b0;
          beat    <= 1'b0;
          if (complete) begin
            if (!head_cxl) begin
              data_ok_q <= 1'b1;
              rdata_q   <= {bus.rdata, lo_eff};
              rvalid1_q <= !a2_q[rd_ptr];
              err_q     <= err_total;
            end
            rd_ptr <= ptr_next(rd_ptr);
          end
        end
      end

      case ({accept, complete})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.inst_sram_addr_ok = accept;
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;
  assign bus.inst_sram_rvalid1 = rvalid1_q;
  assign bus.inst_sram_err     = err_q;

  assign bus.arid    = ARID_VAL;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd1;
  assign bus.arsize  = 3'd2;
  assign bus.arburst = 2'b01;
  assign bus.arcache = arcache_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  // Size is fixed at a word, a single ID is in use, and addr[1:0] is only
  // checked upstream.
  assign unused_bits = ^{bus.inst_sram_size, bus.rid, bus.inst_sram_addr[1:0]};

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed testbench for inst_sram_axi_bridge (MAX_OUT=2). The bench plays
// both the fetch stage and the AXI slave, stepping cycle by cycle. Inputs
// change 1 time unit after a rising edge; outputs are checked 2 units after.
module tb_inst_sram_axi_bridge;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  inst_sram_axi_bridge_if bus ();

  inst_sram_axi_bridge #(
    .MAX_OUT  (2),
    .ARID_VAL (4'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic uncache, input logic cancel);
    bus.inst_sram_req    = req;
    bus.inst_sram_addr   = addr;
    bus.inst_uncache     = uncache;
    bus.inst_sram_cancel = cancel;
  endtask

  // One accepted request: addr_ok in the request cycle, AR visible next.
  task automatic issueRequest(input string tag, input logic [31:0] addr,
                              input logic uncache, input logic [3:0] exp_cache);
    tick();
    applyStimulus(1'b1, addr, uncache, 1'b0);
    #1;
    checkOutput({tag, "_addr_ok"}, 64'(bus.inst_sram_addr_ok), 64'd1);
    tick();
    applyStimulus(1'b0, addr, uncache, 1'b0);
    #1;
    checkOutput({tag, "_arvalid"}, 64'(bus.arvalid), 64'd1);
    checkOutput({tag, "_araddr"}, 64'(bus.araddr), 64'({addr[31:3], 3'b000}));
    checkOutput({tag, "_arcache"}, 64'(bus.arcache), 64'(exp_cache));
  endtask

  // Two beats; returns in the cycle where data_ok should be visible.
  task automatic driveBurst(input logic [31:0] d0, input logic [1:0] r0,
                            input logic [31:0] d1, input logic [1:0] r1);
    tick();
    bus.rvalid = 1'b1; bus.rdata = d0; bus.rresp = r0; bus.rlast = 1'b0;
    tick();
    bus.rdata = d1; bus.rresp = r1; bus.rlast = 1'b1;
    tick();
    bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    #1;
  endtask

  // Single rlast beat with no beat 0 before it.
  task automatic driveLastOnly(input logic [31:0] d1);
    tick();
    bus.rvalid = 1'b1; bus.rdata = d1; bus.rresp = 2'b00; bus.rlast = 1'b1;
    tick();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    #1;
  endtask

  // Directed sequence covering reset, basic fetches, back-pressure,
  // flushes, bus errors and reset mid-burst.
  initial begin
    logic [31:0] addrs [3];
    logic        acc;
    int          pulses;
    int          k;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    bus.inst_sram_size = 2'h2;
    bus.arready = 1'b1;
    bus.rid     = 4'd0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    bus.rvalid  = 1'b0;

    tick(); tick(); tick();
    #1;
    checkOutput("rst_addr_ok", 64'(bus.inst_sram_addr_ok), 64'd0);
    checkOutput("rst_data_ok", 64'(bus.inst_sram_data_ok), 64'd0);
    checkOutput("rst_rdata", bus.inst_sram_rdata, 64'd0);
    checkOutput("rst_rvalid1", 64'(bus.inst_sram_rvalid1), 64'd0);
    checkOutput("rst_err", 64'(bus.inst_sram_err), 64'd0);
    checkOutput("rst_arvalid", 64'(bus.arvalid), 64'd0);
    checkOutput("rst_araddr", 64'(bus.araddr), 64'd0);
    tick();
    reset = 1'b0;

    // Test 1: uncached fetch of the pair base.
    issueRequest("t1", 32'hbfc0_0000, 1'b1, 4'b0000);
    checkOutput("t1_arlen", 64'(bus.arlen), 64'd1);
    checkOutput("t1_arsize", 64'(bus.arsize), 64'd2);
    checkOutput("t1_arburst", 64'(bus.arburst), 64'd1);
    checkOutput("t1_arid", 64'(bus.arid), 64'd0);
    checkOutput("t1_rready", 64'(bus.rready), 64'd1);
    driveBurst(32'h1111_1111, 2'b00, 32'h2222_2222, 2'b00);
    checkOutput("t1_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t1_rdata", bus.inst_sram_rdata, 64'h2222_2222_1111_1111);
    checkOutput("t1_rvalid1", 64'(bus.inst_sram_rvalid1), 64'd1);
    checkOutput("t1_err", 64'(bus.inst_sram_err), 64'd0);
    tick();
    #1;
    checkOutput("t1_data_ok_pulse", 64'(bus.inst_sram_data_ok), 64'd0);
    checkOutput("t1_arvalid_clear", 64'(bus.arvalid), 64'd0);

    // Test 2: upper-half fetch, cached.
    issueRequest("t2", 32'hbfc0_0004, 1'b0, 4'b1111);
    driveBurst(32'h3333_3333, 2'b00, 32'h4444_4444, 2'b00);
    checkOutput("t2_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t2_rdata", bus.inst_sram_rdata, 64'h4444_4444_3333_3333);
    checkOutput("t2_rvalid1", 64'(bus.inst_sram_rvalid1), 64'd0);

    // Test 3: request held high with responses delayed; only two accepts.
    addrs[0] = 32'h0000_1000;
    addrs[1] = 32'h0000_100c;
    addrs[2] = 32'h0000_1010;
    acc    = 1'b0;
    pulses = 0;
    k      = 0;
    tick();
    applyStimulus(1'b1, addrs[0], 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin
        tick();
        if (acc && k < 2) begin
          k++;
          bus.inst_sram_addr = addrs[k];
        end
      end
      #1;
      acc = bus.inst_sram_addr_ok;
      if (acc) pulses++;
    end
    checkOutput("t3_accept_pulses", 64'(pulses), 64'd2);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_00a0; bus.rlast = 1'b0;
    #1;
    checkOutput("t3_full_beat0", 64'(bus.inst_sram_addr_ok), 64'd0);
    tick();
    bus.rdata = 32'h0000_00a1; bus.rlast = 1'b1;
    #1;
    checkOutput("t3_full_pop_cycle", 64'(bus.inst_sram_addr_ok), 64'd0);
    tick();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    #1;
    checkOutput("t3_data_ok0", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t3_rdata0", bus.inst_sram_rdata, 64'h0000_00a1_0000_00a0);
    checkOutput("t3_rvalid1_0", 64'(bus.inst_sram_rvalid1), 64'd1);
    checkOutput("t3_third_accept", 64'(bus.inst_sram_addr_ok), 64'd1);
    tick();
    applyStimulus(1'b0, addrs[2], 1'b0, 1'b0);
    #1;
    checkOutput("t3_third_araddr", 64'(bus.araddr), 64'h0000_1010);
    driveBurst(32'h0000_00b0, 2'b00, 32'h0000_00b1, 2'b00);
    checkOutput("t3_data_ok1", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t3_rdata1", bus.inst_sram_rdata, 64'h0000_00b1_0000_00b0);
    checkOutput("t3_rvalid1_1", 64'(bus.inst_sram_rvalid1), 64'd0);
    driveBurst(32'h0000_00c0, 2'b00, 32'h0000_00c1, 2'b00);
    checkOutput("t3_data_ok2", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t3_rdata2", bus.inst_sram_rdata, 64'h0000_00c1_0000_00c0);
    checkOutput("t3_rvalid1_2", 64'(bus.inst_sram_rvalid1), 64'd1);

    // Test 4: flush two in-flight requests, then a fresh one.
    issueRequest("t4a", 32'h0000_2000, 1'b0, 4'b1111);
    issueRequest("t4b", 32'h0000_2008, 1'b0, 4'b1111);
    tick();
    bus.inst_sram_cancel = 1'b1;
    tick();
    bus.inst_sram_cancel = 1'b0;
    driveBurst(32'h0000_0d00, 2'b00, 32'h0000_0d01, 2'b00);
    checkOutput("t4_cxl_data_ok0", 64'(bus.inst_sram_data_ok), 64'd0);
    driveBurst(32'h0000_0d10, 2'b00, 32'h0000_0d11, 2'b00);
    checkOutput("t4_cxl_data_ok1", 64'(bus.inst_sram_data_ok), 64'd0);
    tick();
    applyStimulus(1'b1, 32'h0000_2010, 1'b0, 1'b1);
    #1;
    checkOutput("t4_cancel_blocks", 64'(bus.inst_sram_addr_ok), 64'd0);
    tick();
    bus.inst_sram_cancel = 1'b0;
    #1;
    checkOutput("t4_new_accept", 64'(bus.inst_sram_addr_ok), 64'd1);
    tick();
    bus.inst_sram_req = 1'b0;
    #1;
    checkOutput("t4_new_araddr", 64'(bus.araddr), 64'h0000_2010);
    driveBurst(32'h0000_0e00, 2'b00, 32'h0000_0e01, 2'b00);
    checkOutput("t4_new_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t4_new_rdata", bus.inst_sram_rdata, 64'h0000_0e01_0000_0e00);

    // Test 5: flush lands on the rlast beat of the head entry.
    issueRequest("t5a", 32'h0000_3000, 1'b0, 4'b1111);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_0f00; bus.rlast = 1'b0;
    tick();
    bus.rdata = 32'h0000_0f01; bus.rlast = 1'b1; bus.inst_sram_cancel = 1'b1;
    tick();
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.inst_sram_cancel = 1'b0;
    #1;
    checkOutput("t5_cxl_on_rlast", 64'(bus.inst_sram_data_ok), 64'd0);
    issueRequest("t5b", 32'h0000_3004, 1'b0, 4'b1111);
    driveBurst(32'h0000_1f00, 2'b00, 32'h0000_1f01, 2'b00);
    checkOutput("t5_next_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t5_next_rdata", bus.inst_sram_rdata, 64'h0000_1f01_0000_1f00);
    checkOutput("t5_next_rvalid1", 64'(bus.inst_sram_rvalid1), 64'd0);

    // Test 6: bus error on beat 0, a clean burst, rlast-only, reset mid-burst.
    issueRequest("t6a", 32'h0000_4000, 1'b0, 4'b1111);
    driveBurst(32'h0000_2a00, 2'b10, 32'h0000_2a01, 2'b00);
    checkOutput("t6_err_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t6_err_set", 64'(bus.inst_sram_err), 64'd1);
    issueRequest("t6b", 32'h0000_4008, 1'b0, 4'b1111);
    driveBurst(32'h0000_2b00, 2'b00, 32'h0000_2b01, 2'b00);
    checkOutput("t6_clean_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t6_clean_err", 64'(bus.inst_sram_err), 64'd0);
    issueRequest("t6c", 32'h0000_4010, 1'b0, 4'b1111);
    driveLastOnly(32'h0000_0055);
    checkOutput("t6_lastonly_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t6_lastonly_rdata", bus.inst_sram_rdata, 64'h0000_0055_0000_0000);

    issueRequest("t6d", 32'h0000_5000, 1'b1, 4'b0000);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h6666_6666; bus.rresp = 2'b10; bus.rlast = 1'b0;
    tick();
    bus.rvalid = 1'b0; bus.rresp = 2'b00;
    reset = 1'b1;
    tick();
    #1;
    checkOutput("t6_rst_data_ok", 64'(bus.inst_sram_data_ok), 64'd0);
    checkOutput("t6_rst_rdata", bus.inst_sram_rdata, 64'd0);
    checkOutput("t6_rst_rvalid1", 64'(bus.inst_sram_rvalid1), 64'd0);
    checkOutput("t6_rst_err", 64'(bus.inst_sram_err), 64'd0);
    checkOutput("t6_rst_arvalid", 64'(bus.arvalid), 64'd0);
    checkOutput("t6_rst_araddr", 64'(bus.araddr), 64'd0);
    tick();
    reset = 1'b0;
    issueRequest("t6e", 32'h0000_6000, 1'b0, 4'b1111);
    issueRequest("t6f", 32'h0000_6008, 1'b0, 4'b1111);
    driveLastOnly(32'h7777_7777);
    checkOutput("t6_post_rst_data_ok", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t6_post_rst_rdata", bus.inst_sram_rdata, 64'h7777_7777_0000_0000);
    checkOutput("t6_post_rst_err", 64'(bus.inst_sram_err), 64'd0);
    driveBurst(32'h0000_8800, 2'b00, 32'h0000_8801, 2'b00);
    checkOutput("t6_post_rst_data_ok2", 64'(bus.inst_sram_data_ok), 64'd1);
    checkOutput("t6_post_rst_rdata2", bus.inst_sram_rdata, 64'h0000_8801_0000_8800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
